fetch_unit: RTL and testbench



---
 rtl/fetch_unit_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 68 ++++++
 rtl/fetch_unit.sv | 151 +++++++++++++++
 tb/tb_fetch_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode definitions: reset PC default, the NOP encoding and
// the prefetch entry layout. Imported by fetch_fifo and fetch_unit.
package fetch_unit_pkg;

   // Default fetch address after reset (overridable per instance).
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // addi x0, x0, 0 -- presented to decode whenever no instruction is valid.
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // One prefetch entry: the fetched word tagged with its address.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   // Sequential word successor; wraps modulo 2^32.
   function automatic logic [31:0] next_word(input logic [31:0] addr);
      return addr + 32'd4;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO for fetch_unit. Power-of-two DEPTH, synchronous clear,
// same-cycle push and pop allowed (count unchanged). Head is read
// combinationally from storage.
module fetch_fifo
   import fetch_unit_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     push,
   input  fetch_entry_t             push_data,
   input  logic                     pop,
   output fetch_entry_t             head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   fetch_entry_t    mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   cnt;
   logic            do_push;
   logic            do_pop;

   assign empty   = (cnt == '0);
   assign full    = (cnt == DEPTH_C);
   assign count   = cnt;
   assign head    = mem[rd_ptr];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Entry storage write.
   // NOTE: storage is deliberately not reset; validity is carried by cnt, so
   // resetting the array would only add reset fan-out for no behavioural gain.
   always_ff @(posedge clk) begin
      if (do_push && !clear)
         mem[wr_ptr] <= push_data;
   end

   // Pointer and occupancy update; clear empties the FIFO like reset.
   // NOTE: all state here uses non-blocking assignment so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction fetch front end. Issues in-order word reads over a
// valid/ready channel, buffers responses in a prefetch FIFO and presents
// Instr/PC/PCPlus4 to decode. A PCSrc redirect flushes the FIFO and drops
// responses still owed for pre-redirect requests.
// Optional: define FETCH_MISALIGN_EN to add the sticky fetch_fault output
// for misaligned redirect targets; otherwise target bits [1:0] are cleared.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] Instr,
   output logic [31:0] PC,
   output logic [31:0] PCPlus4,
   input  logic        PCSrc,
   input  logic [31:0] PCTarget
`ifdef FETCH_MISALIGN_EN
   ,
   output logic        fetch_fault
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [31:0]    fetch_pc;
   logic [31:0]    rsp_pc;
   logic [31:0]    last_pc;
   logic [31:0]    target_pc;
   logic [CW-1:0]  inflight;
   logic [CW-1:0]  discard;
   logic [CW-1:0]  inflight_after_rsp;
   logic [CW-1:0]  fifo_count;
   logic           fifo_full;
   logic           fifo_empty;
   logic           req_fire;
   logic           rsp_drop;
   logic           push;
   logic           pop;
   logic           fault;
   fetch_entry_t   head;
   fetch_entry_t   push_data;

   // Redirect target as loaded into the PC registers.
`ifdef FETCH_MISALIGN_EN
   assign target_pc = PCTarget;
`else
   assign target_pc = PCTarget & 32'hFFFF_FFFC;
`endif

   // Issue is capped so FIFO entries plus outstanding requests never exceed
   // DEPTH; every response therefore has a free slot waiting for it.
   assign imem_req_valid = !rst && !PCSrc && !fault &&
                           ((fifo_count + inflight) < DEPTH_C);
   assign imem_addr      = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // Responses while discard is nonzero belong to pre-redirect requests.
   assign rsp_drop           = (discard != '0);
   assign inflight_after_rsp = inflight - CW'(imem_rsp_valid);

   // Redirect wins over push and pop in its cycle.
   assign push      = imem_rsp_valid && !rsp_drop && !PCSrc;
   assign pop       = instr_valid && instr_ready && !PCSrc;
   assign push_data = '{pc: rsp_pc, instr: imem_rsp_data};

   assign instr_valid = !fifo_empty && !fault;
   assign Instr       = instr_valid ? head.instr : NOP_INSTR;
   assign PC          = instr_valid ? head.pc    : last_pc;
   assign PCPlus4     = next_word(PC);

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clear     (PCSrc),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Fetch/response address tracking and outstanding-request bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         rsp_pc   <= RESET_PC;
         inflight <= '0;
         discard  <= '0;
      end else if (PCSrc) begin
         // Everything still owed by memory is now stale, including any
         // discards already pending; the response of this cycle is dropped.
         fetch_pc <= target_pc;
         rsp_pc   <= target_pc;
         inflight <= inflight_after_rsp;
         discard  <= inflight_after_rsp;
      end else begin
         if (req_fire)
            fetch_pc <= next_word(fetch_pc);
         if (push)
            rsp_pc <= next_word(rsp_pc);
         inflight <= inflight_after_rsp + CW'(req_fire);
         if (imem_rsp_valid && rsp_drop)
            discard <= discard - CW'(1);
      end
   end

   // Remember the last head PC so PC holds steady while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (rst)
         last_pc <= RESET_PC;
      else if (!fifo_empty)
         last_pc <= head.pc;
   end

`ifdef FETCH_MISALIGN_EN
   // Sticky fault on a misaligned redirect target; only reset clears it.
   always_ff @(posedge clk) begin
      if (rst)
         fault <= 1'b0;
      else if (PCSrc && (PCTarget[1:0] != 2'b00))
         fault <= 1'b1;
   end
   assign fetch_fault = fault;
`else
   assign fault = 1'b0;
`endif

   // Protocol checks on the response channel (simulation only).
   always_ff @(posedge clk) begin
      if (!rst && imem_rsp_valid) begin
         assert (inflight != '0);
         assert (!(push && fifo_full));
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a small in-order
// instruction memory model (word = address, configurable latency).
// Define FETCH_MISALIGN_EN to exercise the fetch_fault output.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b1;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'h0;
   logic        instr_valid;
   logic        instr_ready = 1'b1;
   logic [31:0] Instr;
   logic [31:0] PC;
   logic [31:0] PCPlus4;
   logic        PCSrc = 1'b0;
   logic [31:0] PCTarget = 32'h0;
`ifdef FETCH_MISALIGN_EN
   logic        fetch_fault;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int lat = 1;
   int cyc = 0;
   logic [31:0] req_q [$];
   int          due_q [$];

   fetch_unit #(
      .DEPTH    (4),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .Instr          (Instr),
      .PC             (PC),
      .PCPlus4        (PCPlus4),
      .PCSrc          (PCSrc),
      .PCTarget       (PCTarget)
`ifdef FETCH_MISALIGN_EN
      ,
      .fetch_fault    (fetch_fault)
`endif
   );

   always #5 clk = ~clk;

   // Memory model: record accepted requests and retire delivered responses.
   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         req_q.delete();
         due_q.delete();
      end else begin
         if (imem_rsp_valid) begin
            void'(req_q.pop_front());
            void'(due_q.pop_front());
         end
         if (imem_req_valid && imem_req_ready) begin
            req_q.push_back(imem_addr);
            due_q.push_back(cyc + lat - 1);
         end
      end
   end

   // Memory model: present the oldest due response, data = address.
   always @(negedge clk) begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      if (!rst && req_q.size() > 0 && due_q[0] <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = req_q[0];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Advance until instr_valid or the budget runs out; report ticks used.
   task automatic wait_valid(input int max, output int waited);
      waited = 0;
      while (!instr_valid && waited < max) begin
         tick();
         waited++;
      end
      check("wait_valid_timeout", {31'b0, instr_valid}, 32'h1);
   endtask

   initial begin
      int w;

      // Reset state
      repeat (3) tick();
      check("rst_req_valid",   {31'b0, imem_req_valid}, 32'h0);
      check("rst_instr_valid", {31'b0, instr_valid},    32'h0);
      check("rst_instr_nop",   Instr,     32'h0000_0013);
      check("rst_pc",          PC,        32'h0000_0000);
      check("rst_pcplus4",     PCPlus4,   32'h0000_0004);
      check("rst_addr",        imem_addr, 32'h0000_0000);
      rst = 1'b0;

      // Streaming: 2-cycle fill, then one instruction per cycle
      tick();
      check("fill_instr_valid", {31'b0, instr_valid}, 32'h0);
      check("fill_addr",        imem_addr, 32'h0000_0004);
      for (int i = 0; i < 6; i++) begin
         tick();
         check("stream_valid", {31'b0, instr_valid}, 32'h1);
         check("stream_pc",    PC,      32'(i * 4));
         check("stream_instr", Instr,   32'(i * 4));
         check("stream_pc4",   PCPlus4, 32'(i * 4 + 4));
      end

      // Decode stall: FIFO fills to DEPTH, issue stops, nothing lost
      instr_ready = 1'b0;
      repeat (10) tick();
      check("stall_req_valid", {31'b0, imem_req_valid}, 32'h0);
      check("stall_valid",     {31'b0, instr_valid},    32'h1);
      check("stall_pc",        PC,    32'd20);
      check("stall_instr",     Instr, 32'd20);
      instr_ready = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         tick();
         check("release_valid", {31'b0, instr_valid}, 32'h1);
         check("release_pc",    PC,    32'(20 + 4 * i));
         check("release_instr", Instr, 32'(20 + 4 * i));
      end

      // Mid-operation reset, then 3-cycle latency with a redirect while
      // two requests are outstanding
      rst = 1'b1;
      tick();
      tick();
      check("midrst_valid",     {31'b0, instr_valid},    32'h0);
      check("midrst_req_valid", {31'b0, imem_req_valid}, 32'h0);
      check("midrst_pc",        PC,    32'h0);
      check("midrst_instr",     Instr, 32'h0000_0013);
      lat = 3;
      rst = 1'b0;
      tick();
      tick();
      PCSrc    = 1'b1;
      PCTarget = 32'h0000_0100;
      #1;
      check("redir_no_issue", {31'b0, imem_req_valid}, 32'h0);
      tick();
      PCSrc = 1'b0;
      check("redir_flush_valid", {31'b0, instr_valid}, 32'h0);
      check("redir_addr",        imem_addr, 32'h0000_0100);
      wait_valid(20, w);
      check("redir_latency", 32'(w), 32'd4);
      check("redir_pc",      PC,      32'h0000_0100);
      check("redir_instr",   Instr,   32'h0000_0100);
      check("redir_pc4",     PCPlus4, 32'h0000_0104);

      // Back-to-back redirects: latest target wins, stale words all dropped
      PCSrc    = 1'b1;
      PCTarget = 32'h0000_0300;
      tick();
      PCTarget = 32'h0000_0400;
      tick();
      PCSrc = 1'b0;
      check("b2b_addr", imem_addr, 32'h0000_0400);
      wait_valid(30, w);
      check("b2b_pc",    PC,    32'h0000_0400);
      check("b2b_instr", Instr, 32'h0000_0400);
      tick();
      wait_valid(30, w);
      check("b2b_pc_next",    PC,    32'h0000_0404);
      check("b2b_instr_next", Instr, 32'h0000_0404);

      // Redirect in the same cycle as a response and a pop
      rst = 1'b1;
      tick();
      tick();
      lat = 1;
      rst = 1'b0;
      tick();
      tick();
      tick();
      check("same_pre_pc",  PC, 32'h0000_0004);
      check("same_pre_rsp", {31'b0, imem_rsp_valid}, 32'h1);
      PCSrc    = 1'b1;
      PCTarget = 32'h0000_0200;
      tick();
      PCSrc = 1'b0;
      check("same_empty",    {31'b0, instr_valid}, 32'h0);
      check("same_pc_hold",  PC,        32'h0000_0004);
      check("same_instr",    Instr,     32'h0000_0013);
      check("same_addr",     imem_addr, 32'h0000_0200);
      tick();
      check("same_empty2",   {31'b0, instr_valid}, 32'h0);
      tick();
      check("same_valid",    {31'b0, instr_valid}, 32'h1);
      check("same_tgt_pc",   PC,    32'h0000_0200);
      check("same_tgt_inst", Instr, 32'h0000_0200);

      // Address wrap from FFFF_FFF8
      PCSrc    = 1'b1;
      PCTarget = 32'hFFFF_FFF8;
      tick();
      PCSrc = 1'b0;
      check("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
      tick();
      check("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
      tick();
      check("wrap_addr2", imem_addr, 32'h0000_0000);
      check("wrap_pc0",   PC,        32'hFFFF_FFF8);
      tick();
      check("wrap_pc1",   PC,        32'hFFFF_FFFC);
      check("wrap_pc4",   PCPlus4,   32'h0000_0000);
      tick();
      check("wrap_pc2",   PC,        32'h0000_0000);
      check("wrap_inst2", Instr,     32'h0000_0000);

`ifdef FETCH_MISALIGN_EN
      // Misaligned redirect: sticky fault, no issue, no valid until reset
      PCSrc    = 1'b1;
      PCTarget = 32'h0000_0102;
      tick();
      PCSrc = 1'b0;
      check("fault_set",   {31'b0, fetch_fault},    32'h1);
      check("fault_noreq", {31'b0, imem_req_valid}, 32'h0);
      check("fault_noval", {31'b0, instr_valid},    32'h0);
      repeat (5) tick();
      check("fault_sticky",  {31'b0, fetch_fault},    32'h1);
      check("fault_noreq2",  {31'b0, imem_req_valid}, 32'h0);
      check("fault_noval2",  {31'b0, instr_valid},    32'h0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("fault_cleared", {31'b0, fetch_fault}, 32'h0);
      check("fault_rst_addr", imem_addr, 32'h0000_0000);
`else
      // Misaligned target bits are ignored on load
      PCSrc    = 1'b1;
      PCTarget = 32'h0000_0202;
      tick();
      PCSrc = 1'b0;
      check("align_addr", imem_addr, 32'h0000_0200);
      wait_valid(20, w);
      check("align_pc",    PC,    32'h0000_0200);
      check("align_instr", Instr, 32'h0000_0200);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // Global time bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
